// File: rtl/mapu_b_host_if.sv
// Job, MAPU data-plane, MAPU control, result and status signals of the MAPU host block.
// master: the host block itself; slave: the job source, MAPU and result sink around it.
interface mapu_b_host_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      j_vld;
  logic                      j_rdy;
  logic                      j_op;
  logic [4*DATA_WIDTH-1:0]   j_a;
  logic [4*DATA_WIDTH-1:0]   j_b;

  logic                      dpi_vld;
  logic                      dpi_rdy;
  logic [DATA_WIDTH-1:0]     dpi_r0, dpi_r1, dpi_r2, dpi_r3;

  logic                      dpo_vld;
  logic                      dpo_rdy;
  logic [DATA_WIDTH-1:0]     dpo_r0, dpo_r1, dpo_r2, dpo_r3;

  logic                      cp_en;
  logic                      cp_op;
  logic                      cp_of;

  logic                      r_vld;
  logic                      r_rdy;
  logic [4*DATA_WIDTH-1:0]   r_data;
  logic                      r_of;

  logic                      busy;
  logic                      err_to;

  modport master (
    input  j_vld, j_op, j_a, j_b,
    input  dpi_rdy,
    input  dpo_vld, dpo_r0, dpo_r1, dpo_r2, dpo_r3,
    input  cp_of,
    input  r_rdy,
    output j_rdy,
    output dpi_vld, dpi_r0, dpi_r1, dpi_r2, dpi_r3,
    output dpo_rdy,
    output cp_en, cp_op,
    output r_vld, r_data, r_of,
    output busy, err_to
  );

  modport slave (
    output j_vld, j_op, j_a, j_b,
    output dpi_rdy,
    output dpo_vld, dpo_r0, dpo_r1, dpo_r2, dpo_r3,
    output cp_of,
    output r_rdy,
    input  j_rdy,
    input  dpi_vld, dpi_r0, dpi_r1, dpi_r2, dpi_r3,
    input  dpo_rdy,
    input  cp_en, cp_op,
    input  r_vld, r_data, r_of,
    input  busy, err_to
  );
endinterface

// File: rtl/mapu_b_host.sv
// Host sequencer for a 4-row MAPU: takes one job, streams A then B rows, collects the result.
// Optional result watchdog enabled by defining MAPU_B_HOST_TIMEOUT_EN.
module mapu_b_host #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset,
  mapu_b_host_if.master bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RES, PUSH_RES} state_e;

  state_e         state_q, state_d;
  logic           op_q, op_d;
  logic [4*W-1:0] a_q, a_d;
  logic [4*W-1:0] b_q, b_d;
  logic [4*W-1:0] rdata_q, rdata_d;
  logic           rof_q, rof_d;
  logic           dpo_hs;
  logic           timeout;
  logic [4*W-1:0] dpi_rows;

  // Any dpo_vld outside WAIT_RES is ignored because dpo_rdy is low there.
  assign dpo_hs = (state_q == WAIT_RES) && bus.dpo_vld;

`ifdef MAPU_B_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SEND_B && bus.dpi_rdy)
      cnt_d = '0;
    else if (state_q == WAIT_RES && !dpo_hs && !timeout)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A result arriving on the expiry cycle still wins over the timeout.
  assign timeout = (state_q == WAIT_RES) && (cnt_q == CW'(TIMEOUT_CYCLES)) && !dpo_hs;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    rof_d   = rof_q;
    unique case (state_q)
      IDLE: if (bus.j_vld) begin
        op_d    = bus.j_op;
        a_d     = bus.j_a;
        b_d     = bus.j_b;
        state_d = SEND_A;
      end
      SEND_A: if (bus.dpi_rdy) state_d = SEND_B;
      SEND_B: if (bus.dpi_rdy) state_d = WAIT_RES;
      WAIT_RES: begin
        if (dpo_hs) begin
          rdata_d = {bus.dpo_r3, bus.dpo_r2, bus.dpo_r1, bus.dpo_r0};
          rof_d   = bus.cp_of;
          state_d = PUSH_RES;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      PUSH_RES: if (bus.r_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      rof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      rof_q   <= rof_d;
    end
  end

  assign dpi_rows = (state_q == SEND_A) ? a_q :
                    (state_q == SEND_B) ? b_q : '0;

  assign bus.j_rdy   = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.dpi_vld = (state_q == SEND_A) || (state_q == SEND_B);
  assign bus.dpi_r0  = dpi_rows[0*W +: W];
  assign bus.dpi_r1  = dpi_rows[1*W +: W];
  assign bus.dpi_r2  = dpi_rows[2*W +: W];
  assign bus.dpi_r3  = dpi_rows[3*W +: W];
  assign bus.cp_en   = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_RES);
  assign bus.cp_op   = bus.cp_en && op_q;
  assign bus.dpo_rdy = (state_q == WAIT_RES);
  assign bus.r_vld   = (state_q == PUSH_RES);
  assign bus.r_data  = rdata_q;
  assign bus.r_of    = rof_q;
  // Gated so a reset landing on the expiry cycle never reports a timeout.
  assign bus.err_to  = timeout && !reset;
endmodule

// File: tb/tb_mapu_b_host.sv
// Self-checking bench for mapu_b_host: table vectors, random jobs against a row-wise
// arithmetic model of the MAPU, and hand sequences for stalls, reset and the watchdog.
module tb_mapu_b_host;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  mapu_b_host_if #(.DATA_WIDTH(DW)) bus ();

  mapu_b_host #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        of;
    int          a_st;
    int          b_st;
    int          dly;
    int          r_st;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] dpi_rows();
    return {bus.dpi_r3, bus.dpi_r2, bus.dpi_r1, bus.dpi_r0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural MAPU: each 32-bit row is added or multiplied independently, truncated.
  function automatic logic [127:0] mapu_model(input logic op, input logic [127:0] x, input logic [127:0] y);
    logic [127:0] r;
    logic [31:0]  xi, yi;
    for (int i = 0; i < 4; i++) begin
      xi = x[i*32 +: 32];
      yi = y[i*32 +: 32];
      r[i*32 +: 32] = op ? xi * yi : xi + yi;
    end
    return r;
  endfunction

  task automatic drive_dpo(input logic [127:0] v);
    {bus.dpo_r3, bus.dpo_r2, bus.dpo_r1, bus.dpo_r0} = v;
  endtask

  // One full job with programmable stalls; the MAPU stub computes from the rows it received.
  task automatic run_job(input string tag, input logic op, input logic [127:0] ja,
                         input logic [127:0] jb, input logic of, input int a_st,
                         input int b_st, input int dly, input int r_st,
                         input logic [127:0] exp);
    logic [127:0] ra, rb, want;
    int           st;
    ra = '0;
    rb = '0;
    bus.j_vld = 1'b1; bus.j_op = op; bus.j_a = ja; bus.j_b = jb;
    bus.dpi_rdy = 1'b0; bus.r_rdy = 1'b0; bus.dpo_vld = 1'b0;
    #1;
    check({tag, " j_rdy idle"}, bus.j_rdy, 1);
    tick();
    bus.j_vld = 1'b0; bus.j_op = ~op; bus.j_a = rnd128(); bus.j_b = rnd128();
    for (int ph = 0; ph < 2; ph++) begin
      st   = ph ? b_st : a_st;
      want = ph ? jb : ja;
      for (int i = 0; i <= st; i++) begin
        bus.dpi_rdy = (i == st);
        #1;
        check({tag, ph ? " B vld" : " A vld"}, bus.dpi_vld, 1);
        check({tag, ph ? " B rows" : " A rows"}, dpi_rows(), want);
        check({tag, " cp_en/op send"}, {bus.cp_en, bus.cp_op}, {1'b1, op});
        check({tag, " j_rdy/busy send"}, {bus.j_rdy, bus.busy}, 2'b01);
        if (i == st) begin
          if (ph == 0) ra = dpi_rows();
          else         rb = dpi_rows();
        end
        tick();
      end
    end
    bus.dpi_rdy = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      bus.dpo_vld = (i == dly);
      if (i == dly) begin
        drive_dpo(mapu_model(bus.cp_op, ra, rb));
        bus.cp_of = of;
      end
      #1;
      check({tag, " wait dpi_vld/dpo_rdy/cp_en/err"},
            {bus.dpi_vld, bus.dpo_rdy, bus.cp_en, bus.err_to, bus.r_vld}, 5'b01100);
      tick();
    end
    bus.dpo_vld = 1'b0; bus.cp_of = 1'b0; drive_dpo(rnd128());
    for (int i = 0; i <= r_st; i++) begin
      bus.r_rdy = (i == r_st);
      #1;
      check({tag, " r_vld"}, bus.r_vld, 1);
      check({tag, " r_data"}, bus.r_data, exp);
      check({tag, " r_of"}, bus.r_of, of);
      check({tag, " push j_rdy/cp_en/dpo_rdy"}, {bus.j_rdy, bus.cp_en, bus.dpo_rdy}, 3'b000);
      tick();
    end
    bus.r_rdy = 1'b0;
    #1;
    check({tag, " back idle"}, {bus.r_vld, bus.j_rdy, bus.busy}, 3'b010);
  endtask

  // Accept a job and complete both row transfers; returns in the first WAIT_RES cycle.
  task automatic go_wait(input logic op);
    bus.j_vld = 1'b1; bus.j_op = op; bus.j_a = rnd128(); bus.j_b = rnd128();
    tick();
    bus.j_vld = 1'b0; bus.dpi_rdy = 1'b1;
    tick();
    tick();
    bus.dpi_rdy = 1'b0;
  endtask

  vec_t         vt[6];
  logic         rop, rof;
  logic [127:0] ra, rb;

  initial begin
    vt[0] = '{1'b0, 32'h01010101, 32'h02020202, 1'b0, 0, 0, 0, 0, 32'h03030303};
    vt[1] = '{1'b1, 32'h00000003, 32'h00000005, 1'b0, 0, 0, 0, 0, 32'h0000000f};
    vt[2] = '{1'b0, 32'hffffffff, 32'h00000001, 1'b1, 0, 1, 2, 0, 32'h00000000};
    vt[3] = '{1'b1, 32'h00010000, 32'h00010000, 1'b1, 1, 0, 0, 1, 32'h00000000};
    vt[4] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 5, 0, 0, 0, 32'h23456789};
    vt[5] = '{1'b1, 32'h00000100, 32'h00000007, 1'b1, 0, 0, 1, 3, 32'h00000700};

    reset = 1'b1;
    bus.j_vld = 0; bus.j_op = 0; bus.j_a = '0; bus.j_b = '0;
    bus.dpi_rdy = 0; bus.dpo_vld = 0; bus.cp_of = 0; bus.r_rdy = 0;
    drive_dpo('0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset j_rdy", bus.j_rdy, 1);
    check("reset outputs", {bus.busy, bus.dpi_vld, bus.dpo_rdy, bus.cp_en, bus.cp_op,
                            bus.r_vld, bus.r_of, bus.err_to}, 8'h00);
    check("reset dpi rows", dpi_rows(), '0);
    check("reset r_data", bus.r_data, '0);

    // Result-plane traffic while idle must be ignored.
    bus.dpo_vld = 1'b1; bus.cp_of = 1'b1; drive_dpo(rnd128());
    tick();
    tick();
    check("idle dpo ignored", {bus.busy, bus.r_vld, bus.dpo_rdy, bus.r_of}, 4'b0000);
    check("idle dpo no capture", bus.r_data, '0);
    bus.dpo_vld = 1'b0; bus.cp_of = 1'b0;

    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vt[i].op, {4{vt[i].a}}, {4{vt[i].b}}, vt[i].of,
              vt[i].a_st, vt[i].b_st, vt[i].dly, vt[i].r_st, {4{vt[i].exp}});

    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom_range(0, 1));
      rof = 1'($urandom_range(0, 1));
      ra  = rnd128();
      rb  = rnd128();
      tick();
      run_job($sformatf("rnd%0d", i), rop, ra, rb, rof, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), mapu_model(rop, ra, rb));
    end

    // Reset while waiting for the result, with a result offered in the same cycle.
    tick();
    go_wait(1'b1);
    tick();
    reset = 1'b1; bus.dpo_vld = 1'b1; bus.cp_of = 1'b1; drive_dpo(rnd128());
    tick();
    reset = 1'b0;
    #1;
    check("rst mid idle", {bus.busy, bus.j_rdy, bus.cp_en, bus.dpo_rdy}, 4'b0100);
    check("rst mid no result", {bus.r_vld, bus.r_of, bus.err_to}, 3'b000);
    check("rst mid r_data", bus.r_data, '0);
    tick();
    check("rst mid still idle", {bus.busy, bus.r_vld, bus.err_to}, 3'b000);
    bus.dpo_vld = 1'b0; bus.cp_of = 1'b0;
    tick();

`ifdef MAPU_B_HOST_TIMEOUT_EN
    go_wait(1'b0);
    for (int k = 0; k < TO; k++) begin
      #1;
      check($sformatf("to quiet %0d", k), {bus.busy, bus.err_to}, 2'b10);
      tick();
    end
    #1;
    check("to pulse", {bus.err_to, bus.r_vld}, 2'b10);
    tick();
    check("to after", {bus.j_rdy, bus.err_to, bus.r_vld, bus.busy}, 4'b1000);
`else
    go_wait(1'b0);
    for (int k = 0; k < 30; k++) begin
      #1;
      check($sformatf("no-to wait %0d", k), {bus.busy, bus.dpo_rdy, bus.err_to}, 3'b110);
      tick();
    end
    ra = rnd128();
    bus.dpo_vld = 1'b1; drive_dpo(ra);
    tick();
    bus.dpo_vld = 1'b0; bus.r_rdy = 1'b1;
    #1;
    check("no-to late result", {bus.r_vld, bus.r_data}, {1'b1, ra});
    tick();
    bus.r_rdy = 1'b0;
    #1;
    check("no-to back idle", {bus.j_rdy, bus.err_to}, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
